// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame timing
// that the transmitter also uses, so both ends agree on baud and width.
package uart_rx_pkg;

  localparam int BPS_MAX_DEF = 5208;
  localparam int BIT_MAX_DEF = 8;

  // Counter widths cover BPS_MAX up to 2^26-1 and BIT_MAX up to 15
  localparam int BPS_CNT_W = 26;
  localparam int BIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a third flop for
// falling-edge detection. All flops reset to 1 so a reset looks like an idle line.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic line,
  output logic fall
);

  logic sync_m;
  logic sync;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_m <= 1'b1;
      sync   <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync_m <= rx;
      sync   <= sync_m;
      sync_q <= sync;
    end
  end

  assign line = sync;
  assign fall = sync_q & ~sync;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: detects the start edge, samples each bit at mid-bit and
// emits the byte with a one-cycle valid strobe, or an error strobe on a bad stop bit.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BPS_MAX = BPS_MAX_DEF,
  parameter int BIT_MAX = BIT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [BIT_MAX-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_err,
  output logic               rx_busy
);

  localparam logic [BPS_CNT_W-1:0] BPS_LAST = BPS_CNT_W'(BPS_MAX - 1);
  localparam logic [BPS_CNT_W-1:0] SAMPLE   = BPS_CNT_W'(BPS_MAX / 2 - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(BIT_MAX - 1);

  rx_state_t            state;
  logic [BPS_CNT_W-1:0] bps_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_MAX-1:0]   shift;
  logic                 line;
  logic                 fall;
  logic                 at_sample;
  logic                 at_bound;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .line (line),
    .fall (fall)
  );

  assign at_sample = (bps_cnt == SAMPLE);
  assign at_bound  = (bps_cnt == BPS_LAST);

  // Bits arrive LSB first, so shifting in from the top leaves bit 0 at the bottom
  always_ff @(posedge clk) begin
    if (state == DATA && at_sample) begin
      shift <= {line, shift[BIT_MAX-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bps_cnt  <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (state != IDLE) begin
        bps_cnt <= at_bound ? '0 : bps_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (fall) begin
            bps_cnt <= '0;
            bit_cnt <= '0;
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          // A start bit that is high again at mid-bit was only a glitch
          if (at_sample && line) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else if (at_bound) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_bound) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is never missed
          if (at_sample) begin
            if (line) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames at nominal and skewed bit periods and
// checks every strobe cycle against a waveform-sampling model of the receiver.
module tb_uart_rx;

  localparam int B  = 16;
  localparam int H  = B / 2;
  localparam int BD = 5208;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst2;
  logic       rx;
  logic       rx2;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       rx_busy;
  logic [7:0] rx_data2;
  logic       rx_valid2;
  logic       rx_err2;
  logic       rx_busy2;

  uart_rx #(.BPS_MAX(B), .BIT_MAX(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .rx_busy  (rx_busy)
  );

  uart_rx u_dflt (
    .clk      (clk),
    .rst      (rst2),
    .rx       (rx2),
    .rx_data  (rx_data2),
    .rx_valid (rx_valid2),
    .rx_err   (rx_err2),
    .rx_busy  (rx_busy2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int nvalid = 0;
  int nerr   = 0;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] model_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver model: sample the sent waveform at i*B+H cycles after the start
  // edge for bits 0..9; the outcome appears 9.5 bits + 3 clk after the edge.
  task automatic model_frame(input int start, input logic [9:0] bits, input int per);
    logic [7:0] d;
    logic       lv;
    int         idx;
    ev_t        ev;
    d = 8'h00;
    for (int i = 0; i < 10; i++) begin
      idx = (i * B + H) / per;
      lv  = (idx > 9) ? 1'b1 : bits[idx];
      if (i == 0 && lv) return;
      if (i >= 1 && i <= 8) d[i-1] = lv;
      if (i == 9) begin
        ev.cyc  = start + 9 * B + H + 3;
        ev.err  = !lv;
        ev.data = d;
        evq.push_back(ev);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    model_frame(cyc, bits, per);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      idle(per);
    end
  endtask

  always @(negedge clk) begin
    ev_t  ev;
    logic exp_v;
    logic exp_e;
    if (!rst) begin
      evq.delete();
      model_data = 8'h00;
      chk("reset rx_valid", 32'(rx_valid), 32'd0);
      chk("reset rx_err", 32'(rx_err), 32'd0);
      chk("reset rx_data", 32'(rx_data), 32'd0);
      chk("reset rx_busy", 32'(rx_busy), 32'd0);
    end else begin
      exp_v = 1'b0;
      exp_e = 1'b0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev    = evq.pop_front();
        exp_e = ev.err;
        exp_v = !ev.err;
        if (exp_v) model_data = ev.data;
      end
      chk("rx_valid", 32'(rx_valid), 32'(exp_v));
      chk("rx_err", 32'(rx_err), 32'(exp_e));
      if (exp_v || exp_e || rx_valid || rx_err)
        chk("rx_data", 32'(rx_data), 32'(model_data));
      if (rx_valid) nvalid++;
      if (rx_err) nerr++;
    end
  end

  task automatic main_run();
    // back-to-back frames
    send_frame(8'h55, B, 1'b1);
    send_frame(8'hA5, B, 1'b1);
    idle(2 * B);
    chk("t1 data", 32'(rx_data), 32'h0000_00A5);
    chk("t1 count", 32'(nvalid), 32'd2);
    // short low glitch while idle
    rx = 1'b0;
    idle(H - 2);
    rx = 1'b1;
    idle(B - (H - 2));
    chk("t2 busy", 32'(rx_busy), 32'd0);
    idle(B);
    chk("t2 count", 32'(nvalid), 32'd2);
    // bad stop bit, line held low, then recovery
    send_frame(8'h3C, B, 1'b0);
    idle(2 * B);
    chk("t3 data hold", 32'(rx_data), 32'h0000_00A5);
    chk("t3 err count", 32'(nerr), 32'd1);
    rx = 1'b1;
    idle(2 * B);
    send_frame(8'h81, B, 1'b1);
    idle(2 * B);
    chk("t3 data", 32'(rx_data), 32'h0000_0081);
    chk("t3 count", 32'(nvalid), 32'd3);
    // reset during the 4th data bit of 0xFF
    rx = 1'b0;
    idle(B);
    rx = 1'b1;
    idle(3 * B + H);
    chk("t4 busy mid", 32'(rx_busy), 32'd1);
    rst = 1'b0;
    idle(4);
    rst = 1'b1;
    idle(7 * B);
    chk("t4 data cleared", 32'(rx_data), 32'd0);
    send_frame(8'h12, B, 1'b1);
    idle(2 * B);
    chk("t4 data", 32'(rx_data), 32'h0000_0012);
    chk("t4 count", 32'(nvalid), 32'd4);
    // baud skew
    send_frame(8'hC3, B + 1, 1'b1);
    idle(2 * B);
    chk("t5 slow data", 32'(rx_data), 32'h0000_00C3);
    send_frame(8'hC3, B - 1, 1'b1);
    idle(2 * B);
    chk("t5 count", 32'(nvalid), 32'd6);
    chk("t5 err count", 32'(nerr), 32'd1);
    // random traffic
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       stop;
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      send_frame(b, B, stop);
      if (!stop) begin
        rx = 1'b1;
        idle(B);
      end
      idle($urandom_range(0, B));
    end
    idle(2 * B);
  endtask

  task automatic dflt_run();
    int         s;
    int         tgt;
    logic [9:0] bits;
    bits = {1'b1, 8'hA7, 1'b0};
    idle(3);
    s   = cyc;
    tgt = s + 9 * BD + BD / 2 + 3;
    fork
      for (int i = 0; i < 10; i++) begin
        rx2 = bits[i];
        idle(BD);
      end
      begin
        @(negedge clk);
        while (cyc < tgt - 1) @(negedge clk);
        chk("dflt early", 32'(rx_valid2), 32'd0);
        @(negedge clk);
        chk("dflt valid", 32'(rx_valid2), 32'd1);
        chk("dflt data", 32'(rx_data2), 32'h0000_00A7);
        chk("dflt err", 32'(rx_err2), 32'd0);
      end
    join
  endtask

  initial begin
    rst  = 1'b0;
    rst2 = 1'b0;
    rx   = 1'b1;
    rx2  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst  = 1'b1;
    rst2 = 1'b1;
    idle(2);
    fork
      main_run();
      dflt_run();
    join
    for (int i = 0; i < 400 && evq.size() > 0; i++) @(negedge clk);
    chk("drain pending", 32'(evq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
